fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request engine feeding a 2-entry in-order buffer for decode.
// Latency: the word acked at edge N is presented to decode (instr_valid=1) in cycle N+1.
// Backpressure: with two entries buffered, requests stop (HOLD) until decode pops one.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata instruction memory handshake (request held until ack)
//   redirect, redirect_pc   branch/jump resolution pulse and new target
//   instr_valid/ready       decode handshake; instr/instr_pc are the buffer head
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, pc_nxt;     // address of the current / next request
  logic [31:0] target_pc, tgt_nxt;   // redirect target parked while a stale request drains
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];
  logic        head;
  logic [1:0]  count, cnt_nxt;
  logic        push, pop, flush;
  logic        tail;
  logic [31:0] redir_al;
  logic        unused_redir_lsb;

  assign redir_al         = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  assign instr_valid = (count != 2'd0);
  assign instr       = buf_instr[head];
  assign instr_pc    = buf_pc[head];
  assign imem_addr   = fetch_pc;
  assign pop         = instr_valid & instr_ready;

  // Write slot: the head when empty, otherwise the other slot (count never exceeds 1 on a push).
  assign tail = (count == 2'd0) ? head : ~head;

  // Post-edge occupancy; a flush wins over any same-cycle push/pop.
  always_comb begin
    cnt_nxt = count + {1'b0, push} - {1'b0, pop};
    if (flush) begin
      cnt_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = fetch_pc;
    tgt_nxt   = target_pc;
    push      = 1'b0;
    flush     = 1'b0;
    imem_req  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (redirect) begin
          flush  = 1'b1;
          pc_nxt = redir_al;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush = 1'b1;
          if (imem_ack) begin
            // Returned word belongs to the wrong path: drop it, restart at target.
            pc_nxt = redir_al;
          end else begin
            // Request still in flight: keep its address, park the target.
            tgt_nxt   = redir_al;
            state_nxt = DROP;
          end
        end else if (imem_ack) begin
          push   = 1'b1;
          pc_nxt = fetch_pc + 32'd4;
          if (cnt_nxt == 2'd2) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          flush     = 1'b1;
          pc_nxt    = redir_al;
          state_nxt = FETCH;
        end else if (pop) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush   = 1'b1;
          tgt_nxt = redir_al;
        end
        if (imem_ack) begin
          // The newest redirect wins if one lands on the drain cycle.
          pc_nxt    = redirect ? redir_al : target_pc;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      target_pc <= RESET_PC;
      count     <= 2'd0;
      head      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= 32'd0;
        buf_pc[i]    <= 32'd0;
      end
    end else begin
      fetch_pc  <= pc_nxt;
      target_pc <= tgt_nxt;
      count     <= cnt_nxt;
      if (flush) begin
        head <= 1'b0;
      end else if (pop) begin
        head <= ~head;
      end
      if (push) begin
        buf_instr[tail] <= imem_rdata;
        buf_pc[tail]    <= fetch_pc;
      end
    end
  end

endmodule
